// File: rtl/sram_ctrl_pkg.sv
// Shared types and defaults for the SRAM arbiter/sequencer.
// Holds the FSM state enum and the port-index type.
package sram_ctrl_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_ADDR_WIDTH = 7;

   typedef enum logic {
      INIT,
      RUN
   } state_t;

   typedef logic port_t;

endpackage

// File: rtl/sram_arb_ctrl_rr_arb2.sv
// Two-way round-robin arbiter with a one-hot grant.
// The pointer names the port that wins a tie.
module rr_arb2
   import sram_ctrl_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_en,
   input  logic [1:0] i_req,
   output logic [1:0] o_gnt,
   output port_t      o_win
);

   port_t      r_ptr;
   logic [1:0] w_req;

   assign w_req = i_en ? i_req : 2'b00;

   always_comb begin
      o_gnt = 2'b00;
      unique case (w_req)
         2'b01:   o_gnt = 2'b01;
         2'b10:   o_gnt = 2'b10;
         2'b11:   o_gnt = r_ptr ? 2'b10 : 2'b01;
         default: o_gnt = 2'b00;
      endcase
   end

   assign o_win = o_gnt[1];

   // After any grant the loser gets priority next time.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ptr <= 1'b0;
      end else if (|o_gnt) begin
         r_ptr <= ~o_win;
      end
   end

endmodule

// File: rtl/sram_arb_ctrl.sv
// Clears a 1RW SRAM after reset, then shares its port between
// two requesters and routes read data back to the issuing port.
module sram_arb_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter bit INIT_CLEAR = 1'b1
) (
   input  logic                  clk0,
   input  logic                  rst,
   input  logic                  p0_req,
   output logic                  p0_gnt,
   input  logic                  p0_we,
   input  logic [ADDR_WIDTH-1:0] p0_addr,
   input  logic [DATA_WIDTH-1:0] p0_wdata,
   output logic                  p0_rvalid,
   output logic [DATA_WIDTH-1:0] p0_rdata,
   input  logic                  p1_req,
   output logic                  p1_gnt,
   input  logic                  p1_we,
   input  logic [ADDR_WIDTH-1:0] p1_addr,
   input  logic [DATA_WIDTH-1:0] p1_wdata,
   output logic                  p1_rvalid,
   output logic [DATA_WIDTH-1:0] p1_rdata,
   output logic                  sram_csb0,
   output logic                  sram_web0,
   output logic [ADDR_WIDTH-1:0] sram_addr0,
   output logic [DATA_WIDTH-1:0] sram_din0,
   input  logic [DATA_WIDTH-1:0] sram_dout0,
   output logic                  init_done
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_cnt;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_din;
   logic                  r_rd_pend;
   port_t                 r_rd_owner;
   logic [1:0]            r_rvalid;
   logic [DATA_WIDTH-1:0] r_rdata0;
   logic [DATA_WIDTH-1:0] r_rdata1;

   logic                  w_clr;
   logic                  w_run;
   logic                  w_act;
   logic [1:0]            w_req;
   logic [1:0]            w_gnt;
   port_t                 w_win;
   logic                  w_sel_we;
   logic [ADDR_WIDTH-1:0] w_sel_addr;
   logic [DATA_WIDTH-1:0] w_sel_wdata;
   logic                  w_pin_web;
   logic [ADDR_WIDTH-1:0] w_pin_addr;
   logic [DATA_WIDTH-1:0] w_pin_din;

   // Without the clear, RUN behaviour starts as soon as rst drops.
   assign w_clr = !rst && INIT_CLEAR && (r_state == INIT);
   assign w_run = !rst && ((r_state == RUN) || !INIT_CLEAR);
   assign w_req = {p1_req, p0_req};

   rr_arb2 u_arb (
      .i_clk (clk0),
      .i_rst (rst),
      .i_en  (w_run),
      .i_req (w_req),
      .o_gnt (w_gnt),
      .o_win (w_win)
   );

   always_comb begin
      w_sel_we    = p0_we;
      w_sel_addr  = p0_addr;
      w_sel_wdata = p0_wdata;
      if (w_win) begin
         w_sel_we    = p1_we;
         w_sel_addr  = p1_addr;
         w_sel_wdata = p1_wdata;
      end
   end

   always_comb begin
      w_act      = w_clr | (|w_gnt);
      w_pin_web  = ~w_sel_we;
      w_pin_addr = w_sel_addr;
      w_pin_din  = w_sel_wdata;
      if (w_clr) begin
         w_pin_web  = 1'b0;
         w_pin_addr = r_cnt;
         w_pin_din  = '0;
      end
   end

   // Idle cycles keep the last address/data on the macro pins.
   assign sram_csb0  = ~w_act;
   assign sram_web0  = w_act ? w_pin_web : 1'b1;
   assign sram_addr0 = rst ? '0 :
                       (w_act ? w_pin_addr : r_addr);
   assign sram_din0  = rst ? '0 :
                       (w_act ? w_pin_din : r_din);

   assign p0_gnt    = w_gnt[0];
   assign p1_gnt    = w_gnt[1];
   assign init_done = w_run;
   assign p0_rvalid = r_rvalid[0];
   assign p1_rvalid = r_rvalid[1];
   assign p0_rdata  = r_rdata0;
   assign p1_rdata  = r_rdata1;

   always_ff @(posedge clk0) begin
      if (rst) begin
         r_state    <= INIT;
         r_cnt      <= '0;
         r_addr     <= '0;
         r_din      <= '0;
         r_rd_pend  <= 1'b0;
         r_rd_owner <= 1'b0;
         r_rvalid   <= 2'b00;
         r_rdata0   <= '0;
         r_rdata1   <= '0;
      end else begin
         unique case (r_state)
            INIT: begin
               if (INIT_CLEAR) begin
                  r_cnt <= r_cnt + 1'b1;
                  if (r_cnt == LAST_ADDR) begin
                     r_state <= RUN;
                  end
               end else begin
                  r_state <= RUN;
               end
            end
            RUN: begin
               r_state <= RUN;
            end
            default: r_state <= INIT;
         endcase

         if (w_act) begin
            r_addr <= w_pin_addr;
            r_din  <= w_pin_din;
         end

         // Macro data arrives one cycle after the grant.
         r_rd_pend  <= (|w_gnt) && !w_sel_we;
         r_rd_owner <= w_win;
         r_rvalid   <= 2'b00;
         if (r_rd_pend) begin
            if (r_rd_owner) begin
               r_rvalid[1] <= 1'b1;
               r_rdata1    <= sram_dout0;
            end else begin
               r_rvalid[0] <= 1'b1;
               r_rdata0    <= sram_dout0;
            end
         end
      end
   end

endmodule

// File: tb/tb_sram_arb_ctrl.sv
// Randomized bench for sram_arb_ctrl with a behavioural SRAM
// and a scoreboard of the memory contents and due responses.
module tb_sram_arb_ctrl;

   localparam int DW    = 32;
   localparam int AW    = 7;
   localparam int DEPTH = 1 << AW;

   logic clk0 = 1'b0;
   always #5 clk0 = ~clk0;

   logic                rst;
   logic [1:0]          req;
   logic [1:0]          we;
   logic [1:0][AW-1:0]  addr;
   logic [1:0][DW-1:0]  wdata;
   logic [1:0]          gnt;
   logic [1:0]          rvalid;
   logic [1:0][DW-1:0]  rdata;
   logic                csb;
   logic                web;
   logic [AW-1:0]       sa;
   logic [DW-1:0]       sd;
   logic [DW-1:0]       dout;
   logic                done;

   sram_arb_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW),
                   .INIT_CLEAR(1'b1)) dut (
      .clk0(clk0), .rst(rst),
      .p0_req(req[0]), .p0_gnt(gnt[0]), .p0_we(we[0]),
      .p0_addr(addr[0]), .p0_wdata(wdata[0]),
      .p0_rvalid(rvalid[0]), .p0_rdata(rdata[0]),
      .p1_req(req[1]), .p1_gnt(gnt[1]), .p1_we(we[1]),
      .p1_addr(addr[1]), .p1_wdata(wdata[1]),
      .p1_rvalid(rvalid[1]), .p1_rdata(rdata[1]),
      .sram_csb0(csb), .sram_web0(web), .sram_addr0(sa),
      .sram_din0(sd), .sram_dout0(dout), .init_done(done)
   );

   // Second instance without the post-reset clear.
   logic                rst2;
   logic                req2;
   logic [AW-1:0]       addr2;
   logic [1:0]          gnt2;
   logic [1:0]          rvalid2;
   logic [DW-1:0]       rdata2_0;
   logic [DW-1:0]       rdata2_1;
   logic                csb2;
   logic                web2;
   logic [AW-1:0]       sa2;
   logic [DW-1:0]       sd2;
   logic                done2;
   logic [DW-1:0]       zero_d = '0;
   logic [AW-1:0]       zero_a = '0;
   logic                zero_b = 1'b0;

   sram_arb_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW),
                   .INIT_CLEAR(1'b0)) dut2 (
      .clk0(clk0), .rst(rst2),
      .p0_req(req2), .p0_gnt(gnt2[0]), .p0_we(zero_b),
      .p0_addr(addr2), .p0_wdata(zero_d),
      .p0_rvalid(rvalid2[0]), .p0_rdata(rdata2_0),
      .p1_req(zero_b), .p1_gnt(gnt2[1]), .p1_we(zero_b),
      .p1_addr(zero_a), .p1_wdata(zero_d),
      .p1_rvalid(rvalid2[1]), .p1_rdata(rdata2_1),
      .sram_csb0(csb2), .sram_web0(web2), .sram_addr0(sa2),
      .sram_din0(sd2), .sram_dout0(zero_d), .init_done(done2)
   );

   // 1RW macro: inputs latched at posedge, array access at negedge.
   logic [DW-1:0] mem [DEPTH];
   logic          m_csb = 1'b1;
   logic          m_web = 1'b1;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_din;

   always @(posedge clk0) begin
      m_csb  <= csb;
      m_web  <= web;
      m_addr <= sa;
      m_din  <= sd;
   end

   always @(negedge clk0) begin
      if (!m_csb) begin
         if (!m_web) mem[m_addr] <= m_din;
         else        dout <= mem[m_addr];
      end
   end

   // Reference state.
   logic [DW-1:0] ref_mem [DEPTH];
   logic [1:0]    exp_v [4];
   logic [DW-1:0] exp_d [4];
   logic [DW-1:0] exp_rd [2];
   logic [1:0]    gdone;
   logic          prio;
   logic [AW-1:0] last_addr;
   logic [DW-1:0] last_din;
   int            cyc;
   int            n_chk;
   int            n_err;

   task automatic chk(string tag, logic [31:0] got,
                      logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h cyc=%0d",
                  tag, got, exp, cyc);
      end
   endtask

   task automatic tick();
      int s;
      @(posedge clk0);
      #1;
      cyc++;
      s = cyc % 4;
      for (int p = 0; p < 2; p++)
         if (exp_v[s][p]) exp_rd[p] = exp_d[s];
      chk("rvalid", 32'(rvalid), 32'(exp_v[s]));
      chk("rdata0", rdata[0], exp_rd[0]);
      chk("rdata1", rdata[1], exp_rd[1]);
      exp_v[s] = 2'b00;
   endtask

   task automatic set_req(int p, logic w, logic [AW-1:0] a,
                          logic [DW-1:0] d);
      req[p]   = 1'b1;
      we[p]    = w;
      addr[p]  = a;
      wdata[p] = d;
   endtask

   task automatic drop();
      for (int p = 0; p < 2; p++) begin
         if (gdone[p]) begin
            req[p]   = 1'b0;
            gdone[p] = 1'b0;
         end
      end
   endtask

   // Check grant and pins for the current inputs, then log effects.
   task automatic step();
      int         w;
      int         s;
      logic [1:0] eg;
      logic       ewb;
      #1;
      w = -1;
      if (req[0] && req[1]) w = prio ? 1 : 0;
      else if (req[0])      w = 0;
      else if (req[1])      w = 1;
      eg = (w < 0) ? 2'b00 : ((w == 0) ? 2'b01 : 2'b10);
      chk("init_done", 32'(done), 32'd1);
      chk("gnt", 32'(gnt), 32'(eg));
      if (w >= 0) begin
         ewb = !we[w];
         chk("csb", 32'(csb), 32'd0);
         chk("web", 32'(web), 32'(ewb));
         chk("addr", 32'(sa), 32'(addr[w]));
         chk("din", sd, wdata[w]);
         last_addr = addr[w];
         last_din  = wdata[w];
         if (we[w]) begin
            ref_mem[addr[w]] = wdata[w];
         end else begin
            s = (cyc + 2) % 4;
            exp_v[s][w] = 1'b1;
            exp_d[s]    = ref_mem[addr[w]];
         end
         prio     = (w == 0);
         gdone[w] = 1'b1;
      end else begin
         chk("idle_csb", 32'(csb), 32'd1);
         chk("idle_web", 32'(web), 32'd1);
         chk("idle_addr", 32'(sa), 32'(last_addr));
         chk("idle_din", sd, last_din);
      end
   endtask

   task automatic run(int n);
      repeat (n) begin
         drop();
         step();
         tick();
      end
   endtask

   task automatic do_reset(int n);
      rst = 1'b1;
      for (int s = 0; s < 4; s++) exp_v[s] = 2'b00;
      exp_rd[0] = '0;
      exp_rd[1] = '0;
      gdone     = 2'b00;
      prio      = 1'b0;
      set_req(0, 1'b0, 7'd5, 32'd0);
      set_req(1, 1'b1, 7'h20, 32'h1234_5678);
      for (int i = 0; i < n; i++) begin
         #1;
         chk("rst_gnt", 32'(gnt), 32'd0);
         chk("rst_csb", 32'(csb), 32'd1);
         chk("rst_web", 32'(web), 32'd1);
         chk("rst_addr", 32'(sa), 32'd0);
         chk("rst_din", sd, 32'd0);
         chk("rst_done", 32'(done), 32'd0);
         tick();
      end
      rst = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         #1;
         chk("init_gnt", 32'(gnt), 32'd0);
         chk("init_csb", 32'(csb), 32'd0);
         chk("init_web", 32'(web), 32'd0);
         chk("init_addr", 32'(sa), 32'(i));
         chk("init_din", sd, 32'd0);
         chk("init_done0", 32'(done), 32'd0);
         tick();
      end
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      last_addr = AW'(DEPTH - 1);
      last_din  = '0;
   endtask

   task automatic rand_run(int n);
      repeat (n) begin
         drop();
         for (int p = 0; p < 2; p++) begin
            if (!req[p] && $urandom_range(0, 3) != 0)
               set_req(p, 1'($urandom_range(0, 1)),
                       AW'($urandom_range(0, 15)), $urandom);
         end
         step();
         tick();
      end
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      cyc   = 0;
      rst   = 1'b1;
      req   = '0;
      we    = '0;
      addr  = '0;
      wdata = '0;
      rst2  = 1'b1;
      req2  = 1'b1;
      addr2 = 7'd3;

      do_reset(3);
      run(4);

      drop();
      set_req(1, 1'b1, 7'h10, 32'hDEAD_BEEF);
      step();
      tick();
      drop();
      set_req(1, 1'b0, 7'h10, 32'd0);
      step();
      tick();
      run(4);

      repeat (12) begin
         drop();
         for (int p = 0; p < 2; p++)
            if (!req[p])
               set_req(p, 1'b0, AW'($urandom_range(0, 31)), 32'd0);
         step();
         tick();
      end
      run(4);

      for (int a = 1; a <= 3; a++) begin
         drop();
         set_req(1, 1'b1, AW'(a), $urandom);
         step();
         tick();
      end
      for (int a = 1; a <= 3; a++) begin
         drop();
         set_req(0, 1'b0, AW'(a), 32'd0);
         step();
         tick();
      end
      run(4);

      rand_run(300);
      run(4);

      drop();
      req = '0;
      set_req(0, 1'b0, 7'd5, 32'd0);
      step();
      tick();
      do_reset(2);
      run(4);
      rand_run(120);
      run(4);

      @(posedge clk0);
      #1;
      chk("nc_rst_gnt", 32'(gnt2), 32'd0);
      chk("nc_rst_done", 32'(done2), 32'd0);
      rst2 = 1'b0;
      #1;
      chk("nc_done", 32'(done2), 32'd1);
      chk("nc_gnt", 32'(gnt2), 32'd1);
      chk("nc_csb", 32'(csb2), 32'd0);
      chk("nc_addr", 32'(sa2), 32'd3);
      @(posedge clk0);
      #1;
      req2 = 1'b0;
      #1;
      chk("nc_done2", 32'(done2), 32'd1);
      chk("nc_idle", 32'(csb2), 32'd1);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/sram_arb_ctrl.md
# sram_arb_ctrl

Two-port round-robin arbiter and sequencer for one 1RW 32x128 SRAM macro, in the CBG component set. After reset it clears the whole array to zero. It then shares the single RW port between two requesters, for example the PE datapath on port 0 and the config/DMA loader on port 1. Each read response is routed back to the port that issued it.

## Interface
Parameters:
- DATA_WIDTH, 32, word width; must match the macro.
- ADDR_WIDTH, 7, address width; the array holds 1<<ADDR_WIDTH words.
- INIT_CLEAR, 1, selects the post-reset behaviour: 1 zero-fills the array after reset, 0 skips the fill.

Ports:
- clk0  in  1  clock; all logic is on posedge.
- rst  in  1  reset, synchronous and active-high.
- pN_req  in  1  access request from port N (N = 0, 1).
- pN_gnt  out  1  port N's access is accepted this cycle.
- pN_we  in  1  1 = write, 0 = read.
- pN_addr  in  ADDR_WIDTH  word address.
- pN_wdata  in  DATA_WIDTH  write data.
- pN_rvalid  out  1  one-cycle pulse; pN_rdata is valid.
- pN_rdata  out  DATA_WIDTH  read data.
- sram_csb0  out  1  chip select to the macro, active-low.
- sram_web0  out  1  write enable to the macro, active-low.
- sram_addr0  out  ADDR_WIDTH  macro address.
- sram_din0  out  DATA_WIDTH  macro write data.
- sram_dout0  in  DATA_WIDTH  macro read data.
- init_done  out  1  high once the controller is in RUN.

## Operation
FSM states are INIT and RUN.
- **Reset:** rst forces state INIT, clear counter = 0, rr pointer = port 0, rd_pend = 0. Output reset values:
  - all gnt = 0, rvalid = 0, rdata = 0, init_done = 0;
  - sram_csb0 = 1, sram_web0 = 1, sram_addr0 = 0, sram_din0 = 0.
- **INIT, INIT_CLEAR = 1:**
  - Each cycle drives csb0 = 0, web0 = 0, addr0 = counter, din0 = 0, then increments the counter.
  - After the write to address RAM_DEPTH-1, the FSM moves to RUN. INIT therefore lasts exactly RAM_DEPTH cycles.
  - No gnt is issued during INIT; requests are held off, not dropped.
- **INIT, INIT_CLEAR = 0:** the FSM goes to RUN on the first cycle after rst deasserts, with no SRAM access.
- **RUN, grant logic:**
  - gnt is combinational. A single requester is granted. If both request, the port selected by the rr pointer wins.
  - After any grant, the pointer moves to the non-granted port. With no grant, the pointer holds.
  - At most one gnt is high per cycle.
- **RUN, SRAM drive:** in the grant cycle, the SRAM pins are driven combinationally from the winner: csb0 = 0, web0 = ~we, addr0 = addr, din0 = wdata. With no grant, csb0 = 1, web0 = 1, and addr0/din0 hold their last values.
- **Read tracking:**
  - A granted read sets rd_pend = 1 and rd_owner = winner, registered at the end of the grant cycle.
  - While rd_pend = 1, sram_dout0 is captured into the owner's pN_rdata at the next posedge, and pN_rvalid pulses for one cycle.
  - The other port's rdata is unchanged. rdata holds its value between responses.
- **Writes:** a granted write produces no response.
- **Address width:** addresses are used as-is, with no wrap or range check; width equals ADDR_WIDTH.

## Timing
- **Request/grant:** a request is held until granted. Stimulus must keep req, we, addr and wdata stable while req is high and gnt is low. Request and grant complete in the same cycle (cycle N).
- **Read latency:** the grant is in cycle N; the macro registers its inputs at the end of N; dout settles after the negedge in N+1; rvalid and rdata are visible in cycle N+2. Latency is 2 cycles.
- **Throughput:**
  - One access per cycle.
  - Back-to-back reads pipeline with no bubble.
  - The macro reads and writes at the negedge of the cycle after the grant, so a read granted the cycle after a write to the same address returns the new data.
- **Reset mid-operation:** an in-flight read is discarded, with no rvalid. The clear restarts from address 0.
- **Reset with requests pending:** if rst is asserted in the same cycle as req, no gnt is issued.

## Structure
- **Package sram_ctrl_pkg:**
  - state enum {INIT, RUN};
  - 1-bit port-index type;
  - default DATA_WIDTH/ADDR_WIDTH constants.
- **Sub-module rr_arb2:** the two-way round-robin arbiter, containing the pointer register, the req inputs and a one-hot gnt output.
- **Top level:** the FSM, clear counter, SRAM mux and response pipeline.

## Test plan
- **Reset and clear:** reset with INIT_CLEAR = 1. Expect init_done to rise after 128 cycles, 128 writes of 0 at addresses 0..127, and no gnt during that time. A later p0 read of address 5 returns 0.
- **Single-port write/read:** p1 writes 0xDEADBEEF to address 0x10, then reads 0x10 one cycle later. p1_rvalid pulses 2 cycles after the read grant with 0xDEADBEEF; p0_rvalid stays 0.
- **Contention:** both ports request reads continuously. Grants alternate p0, p1, p0, … starting with p0. Each rvalid goes to the correct port with that port's data.
- **Back-to-back reads:** p0 reads addresses 1, 2, 3 on consecutive cycles. rvalid is high for 3 consecutive cycles, in order, with no bubble.
- **Reset mid-read:** assert rst in the cycle after a read grant. No rvalid appears, init restarts from address 0, and all outputs take their reset values.
- **No clear:** with INIT_CLEAR = 0, init_done is high in the first cycle after reset. A request in that cycle is granted.
